// File: rtl/fpga_status_led_ctrl.sv
// Board status LED controller: per-channel OFF/ON/BLINK/PATTERN on a shared tick,
// with channel 0 overridden by a blink-coded exit value. Optional PWM: STATUS_LED_PWM_EN.

module fpga_status_led_chan #(
    parameter int PATTERN_W = 8,
    parameter int IDX_W     = $clog2(PATTERN_W)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           mode,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic                 blink,
    input  logic [IDX_W-1:0]     idx,
    input  logic                 ovr_en,
    input  logic                 ovr_val,
    input  logic                 gate,
    output logic                 led
);
    logic raw;

    always_comb begin
        raw = 1'b0;
        unique case (mode)
            2'd0: raw = 1'b0;
            2'd1: raw = 1'b1;
            2'd2: raw = blink;
            2'd3: raw = pattern[idx];
            default: raw = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) led <= 1'b0;
        else         led <= (ovr_en ? ovr_val : raw) & gate;
    end
endmodule

module fpga_status_led_ctrl #(
    parameter int NUM_LEDS  = 4,
    parameter int TICK_DIV  = 12_500_000,
    parameter int PATTERN_W = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NUM_LEDS-1:0][1:0]            mode_i,
    input  logic [NUM_LEDS-1:0][PATTERN_W-1:0]  pattern_i,
    input  logic [NUM_LEDS-1:0][7:0]            brightness_i,
    input  logic                                exit_valid_i,
    input  logic [31:0]                         exit_value_i,
    output logic                                tick_o,
    output logic                                exit_busy_o,
    output logic [NUM_LEDS-1:0]                 led_o
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int IDX_W = $clog2(PATTERN_W);

    typedef enum logic [2:0] {IDLE, PASS, PULSE_ON, PULSE_OFF, GAP} exit_state_t;

    logic [CNT_W-1:0]    presc;
    logic                blink;
    logic [IDX_W-1:0]    idx;
    logic                valid_q;
    exit_state_t         state, state_n;
    logic [3:0]          reload, reload_n;
    logic [3:0]          pulse_cnt, pulse_n;
    logic [2:0]          gap_cnt, gap_n;
    logic [NUM_LEDS-1:0] gate;
    logic                ovr_val;

    assign tick_o      = (presc == CNT_W'(TICK_DIV - 1));
    assign exit_busy_o = (state != IDLE);
    assign ovr_val     = (state == PASS) || (state == PULSE_ON);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc <= '0;
            blink <= 1'b0;
            idx   <= '0;
        end else begin
            presc <= tick_o ? '0 : presc + 1'b1;
            if (tick_o) begin
                blink <= ~blink;
                idx   <= idx + 1'b1;
            end
        end
    end

    // valid_q resets low so a valid held high across reset reads as a new edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            valid_q   <= 1'b0;
            reload    <= '0;
            pulse_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_n;
            valid_q   <= exit_valid_i;
            reload    <= reload_n;
            pulse_cnt <= pulse_n;
            gap_cnt   <= gap_n;
        end
    end

    always_comb begin
        state_n  = state;
        reload_n = reload;
        pulse_n  = pulse_cnt;
        gap_n    = gap_cnt;
        if (state == IDLE) begin
            if (exit_valid_i && !valid_q) begin
                if (exit_value_i == 32'd0) begin
                    state_n = PASS;
                end else begin
                    reload_n = (exit_value_i > 32'd15) ? 4'd15 : exit_value_i[3:0];
                    pulse_n  = reload_n;
                    state_n  = PULSE_ON;
                end
            end
        end else if (!exit_valid_i) begin
            state_n = IDLE;
        end else if (tick_o) begin
            unique case (state)
                PULSE_ON: state_n = PULSE_OFF;
                PULSE_OFF: begin
                    pulse_n = pulse_cnt - 4'd1;
                    if (pulse_cnt == 4'd1) begin
                        state_n = GAP;
                        gap_n   = 3'd4;
                    end else begin
                        state_n = PULSE_ON;
                    end
                end
                GAP: begin
                    if (gap_cnt == 3'd1) begin
                        state_n = PULSE_ON;
                        pulse_n = reload;
                    end else begin
                        gap_n = gap_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef STATUS_LED_PWM_EN
    logic [7:0] pwm_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pwm_cnt <= '0;
        else         pwm_cnt <= pwm_cnt + 8'd1;
    end

    always_comb begin
        for (int ch = 0; ch < NUM_LEDS; ch++)
            gate[ch] = (brightness_i[ch] == 8'hFF) || (pwm_cnt < brightness_i[ch]);
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness_i;
    assign gate = '1;
`endif

    for (genvar ch = 0; ch < NUM_LEDS; ch++) begin : g_chan
        fpga_status_led_chan #(.PATTERN_W(PATTERN_W)) u_chan (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .mode    (mode_i[ch]),
            .pattern (pattern_i[ch]),
            .blink   (blink),
            .idx     (idx),
            .ovr_en  ((ch == 0) ? exit_busy_o : 1'b0),
            .ovr_val (ovr_val),
            .gate    (gate[ch]),
            .led     (led_o[ch])
        );
    end
endmodule
